// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_pkg
// Description : Shared defaults, FSM encoding and seven-segment patterns
//               for the count BCD reader.
// Revision    : 1.0 - initial release
// ============================================================================
package count_pkg;

    localparam int c_BIN_W  = 13;
    localparam int c_DIGITS = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Active-low segments, bit order g..a
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

endpackage : count_pkg
`default_nettype wire

// File: rtl/bcd_to_sevenseg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_sevenseg
// Description : Combinational BCD digit to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_sevenseg
    import count_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = c_SEG_0;
            4'd1:    o_seg = c_SEG_1;
            4'd2:    o_seg = c_SEG_2;
            4'd3:    o_seg = c_SEG_3;
            4'd4:    o_seg = c_SEG_4;
            4'd5:    o_seg = c_SEG_5;
            4'd6:    o_seg = c_SEG_6;
            4'd7:    o_seg = c_SEG_7;
            4'd8:    o_seg = c_SEG_8;
            4'd9:    o_seg = c_SEG_9;
            default: o_seg = c_SEG_BLANK;
        endcase
    end

endmodule : bcd_to_sevenseg
`default_nettype wire

// File: rtl/count_bcd_reader.sv
`default_nettype none
// ============================================================================
// Module      : count_bcd_reader
// Description : Samples the event counter and converts it to BCD with a
//               bit-serial double-dabble engine. Optional segment outputs
//               are enabled by defining COUNT_BCD_SEVENSEG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module count_bcd_reader
    import count_pkg::*;
#(
    parameter int BIN_W  = c_BIN_W,
    parameter int DIGITS = c_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  valid,
`ifdef COUNT_BCD_SEVENSEG_EN
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   hex_out
`else
    output logic [4*DIGITS-1:0]   bcd_out
`endif
);

    localparam int               c_CNT_W = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    state_t                r_state;
    logic [BIN_W-1:0]      r_bin;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_busy;
    logic                  r_valid;
    logic [4*DIGITS-1:0]   r_bcd;

    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_next_scratch;
    logic [BIN_W-1:0]      w_next_bin;

    // Add-3 on every digit >= 5 before the shift; max 9+3 = 12 fits a nibble
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_next_scratch = {w_adj[4*DIGITS-2:0], r_bin[BIN_W-1]};
    assign w_next_bin     = {r_bin[BIN_W-2:0], 1'b0};

`ifdef COUNT_BCD_SEVENSEG_EN
    logic [7*DIGITS-1:0] w_hex;
    logic [7*DIGITS-1:0] r_hex;

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_to_sevenseg u_dec (
            .i_digit (w_next_scratch[4*g +: 4]),
            .o_seg   (w_hex[7*g +: 7])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex <= {DIGITS{c_SEG_0}};
        end else if (r_state == ST_SHIFT && r_cnt == c_LAST) begin
            r_hex <= w_hex;
        end
    end

    assign hex_out = r_hex;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin     <= bin_in;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bin     <= w_next_bin;
                    r_scratch <= w_next_scratch;
                    r_cnt     <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_bcd   <= w_next_scratch;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign valid   = r_valid;
    assign bcd_out = r_bcd;

endmodule : count_bcd_reader
`default_nettype wire
